// File: rtl/serial_addsub_datapath_if.sv
// Operand, control and result signals of the bit-serial add/subtract datapath.
// The slave side is the datapath; the master side is the control/operand source.
interface serial_addsub_datapath_if #(
   parameter int WIDTH = 4
) ();
   logic             CARRY_IN;
   logic             CTRL_IN_A;
   logic [2:0]       CTRL_IN_B;
   logic [WIDTH-1:0] A_IN;
   logic [WIDTH-1:0] B_IN;
   logic             IN_VALID;
   logic             IN_READY;
   logic             SERIAL_BIT;
   logic [WIDTH:0]   SUM_OUT;
   logic [WIDTH-1:0] DIFF_OUT;
   logic             BORROW_OUT;
   logic             RESULT_VALID;
   logic             SYNC_ERR;

   modport slave (
      input  CARRY_IN, CTRL_IN_A, CTRL_IN_B, A_IN, B_IN, IN_VALID,
      output IN_READY, SERIAL_BIT, SUM_OUT, DIFF_OUT, BORROW_OUT, RESULT_VALID, SYNC_ERR
   );

   modport master (
      output CARRY_IN, CTRL_IN_A, CTRL_IN_B, A_IN, B_IN, IN_VALID,
      input  IN_READY, SERIAL_BIT, SUM_OUT, DIFF_OUT, BORROW_OUT, RESULT_VALID, SYNC_ERR
   );
endinterface

// File: rtl/serial_addsub_datapath.sv
// Bit-serial 4-bit add then subtract over an 8-cycle frame, with a control-sequence checker.
// Only WIDTH=4 is meaningful: the bit index is derived from the 3-bit frame position.
module serial_addsub_datapath #(
   parameter int WIDTH    = 4,
   parameter bit CHECK_EN = 1'b1
) (
   input  logic                           CLK,
   input  logic                           RST,
   serial_addsub_datapath_if.slave        bus
);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [WIDTH-1:0] op_a_p0;
   logic [WIDTH-1:0] op_b_p0;
   logic             vld_p0;
   logic             carry_p1;
   logic [WIDTH-1:0] res_sr_p1;
   logic [WIDTH:0]   sum_hold_p1;
   logic [WIDTH:0]   sum_p2;
   logic [WIDTH-1:0] diff_p2;
   logic             borrow_p2;
   logic             vld_p2;
   logic             err_frame;
   logic             sync_err;
   logic             chk_arm;
   logic [2:0]       prev_b;

   logic             load;
   logic [1:0]       bit_idx;
   logic             y;
   logic             cin;
   logic             sbit;
   logic             cout;
   logic [WIDTH-1:0] res_next;
   logic             phase_a_exp;
   logic             err_now;

   // Phase B bit 3 shares the load cycle and still reads the outgoing operands.
   assign load     = (bus.CTRL_IN_B == 3'd0);
   assign bit_idx  = bus.CTRL_IN_B[1:0] - 2'd1;
   assign y        = op_b_p0[bit_idx] ^ bus.CARRY_IN;
   assign cin      = (bit_idx == 2'd0) ? bus.CARRY_IN : carry_p1;
   assign sbit     = op_a_p0[bit_idx] ^ y ^ cin;
   assign cout     = maj3(op_a_p0[bit_idx], y, cin);
   assign res_next = {sbit, res_sr_p1[WIDTH-1:1]};

   assign phase_a_exp = (bus.CTRL_IN_B >= 3'd1) && (bus.CTRL_IN_B <= 3'd4);
   assign err_now     = CHECK_EN && chk_arm &&
                        ((bus.CTRL_IN_B != prev_b + 3'd1) ||
                         (bus.CTRL_IN_A != phase_a_exp) ||
                         (bus.CARRY_IN == bus.CTRL_IN_A));

   assign bus.IN_READY     = load;
   assign bus.SERIAL_BIT   = sbit;
   assign bus.SUM_OUT      = sum_p2;
   assign bus.DIFF_OUT     = diff_p2;
   assign bus.BORROW_OUT   = borrow_p2;
   assign bus.RESULT_VALID = vld_p2;
   assign bus.SYNC_ERR     = sync_err;

   always_ff @(posedge CLK) begin
      if (RST) begin
         op_a_p0     <= '0;
         op_b_p0     <= '0;
         vld_p0      <= 1'b0;
         carry_p1    <= 1'b0;
         res_sr_p1   <= '0;
         sum_hold_p1 <= '0;
         sum_p2      <= '0;
         diff_p2     <= '0;
         borrow_p2   <= 1'b0;
         vld_p2      <= 1'b0;
         err_frame   <= 1'b0;
         sync_err    <= 1'b0;
         chk_arm     <= 1'b0;
         prev_b      <= 3'd0;
      end else begin
         // p0 -> p1: one serial bit per cycle into the carry and result shift register
         carry_p1  <= cout;
         res_sr_p1 <= res_next;
         if (bus.CTRL_IN_B == 3'd4)
            sum_hold_p1 <= {cout, res_next};

         chk_arm  <= 1'b1;
         prev_b   <= bus.CTRL_IN_B;
         sync_err <= sync_err | err_now;

         // p1 -> p2: publish at the end of phase B, unless the frame was invalid or disturbed
         vld_p2 <= 1'b0;
         if (load) begin
            op_a_p0   <= bus.A_IN;
            op_b_p0   <= bus.B_IN;
            vld_p0    <= bus.IN_VALID;
            err_frame <= 1'b0;
            if (vld_p0 && !err_frame && !err_now) begin
               sum_p2    <= sum_hold_p1;
               diff_p2   <= res_next;
               borrow_p2 <= ~cout;
               vld_p2    <= 1'b1;
            end
         end else if (err_now) begin
            err_frame <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub_datapath.sv
// Directed bench: drives ideal 8-cycle control frames and checks each frame's published result.
module tb_serial_addsub_datapath;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   serial_addsub_datapath_if #(.WIDTH(4)) bus  ();
   serial_addsub_datapath_if #(.WIDTH(4)) bus0 ();

   serial_addsub_datapath #(.WIDTH(4), .CHECK_EN(1'b1)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   // Second copy with the checker disabled, fed the same stimulus.
   assign bus0.CARRY_IN  = bus.CARRY_IN;
   assign bus0.CTRL_IN_A = bus.CTRL_IN_A;
   assign bus0.CTRL_IN_B = bus.CTRL_IN_B;
   assign bus0.A_IN      = bus.A_IN;
   assign bus0.B_IN      = bus.B_IN;
   assign bus0.IN_VALID  = bus.IN_VALID;

   serial_addsub_datapath #(.WIDTH(4), .CHECK_EN(1'b0)) dut0 (
      .CLK (CLK),
      .RST (RST),
      .bus (bus0)
   );

   int         n_tests;
   int         n_fail;
   logic [2:0] pos;

   // Per-frame observations, indexed by frame position.
   logic       ser_a   [8];
   logic       rv_a    [8];
   logic [4:0] sum_a   [8];
   logic [3:0] diff_a  [8];
   logic       bor_a   [8];
   logic       sync_a  [8];
   logic       rdy_a   [8];
   logic       sync0_a [8];
   logic [4:0] sum0_a  [8];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      for (int p = 0; p < 8; p++) begin
         ser_a[p] = 1'b0; rv_a[p] = 1'b0; sum_a[p] = '0; diff_a[p] = '0;
         bor_a[p] = 1'b0; sync_a[p] = 1'b0; rdy_a[p] = 1'b0;
         sync0_a[p] = 1'b0; sum0_a[p] = '0;
      end
   endtask

   task automatic step(input bit rst_now, input bit skip);
      @(posedge CLK);
      #1;
      RST           = rst_now;
      bus.CTRL_IN_B = pos;
      bus.CTRL_IN_A = (pos >= 3'd1) && (pos <= 3'd4);
      bus.CARRY_IN  = !((pos >= 3'd1) && (pos <= 3'd4));
      @(negedge CLK);
      ser_a[pos]   = bus.SERIAL_BIT;
      rv_a[pos]    = bus.RESULT_VALID;
      sum_a[pos]   = bus.SUM_OUT;
      diff_a[pos]  = bus.DIFF_OUT;
      bor_a[pos]   = bus.BORROW_OUT;
      sync_a[pos]  = bus.SYNC_ERR;
      rdy_a[pos]   = bus.IN_READY;
      sync0_a[pos] = bus0.SYNC_ERR;
      sum0_a[pos]  = bus0.SUM_OUT;
      pos = (skip && pos == 3'd3) ? 3'd5 : pos + 3'd1;
   endtask

   task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic v,
                        input int rst_pos, input bit skip);
      clear_obs();
      bus.A_IN     = a;
      bus.B_IN     = b;
      bus.IN_VALID = v;
      for (int s = 0; s < 8; s++) begin
         step(rst_pos == int'(pos), skip);
         if (pos == 3'd0) break;
      end
   endtask

   // Result of the previous frame is visible in position 1 of the current one.
   task automatic check_result(input string tag, input logic rv, input logic [4:0] sum,
                               input logic [3:0] diff, input logic bor);
      int others = 0;
      for (int p = 0; p < 8; p++)
         if (p != 1 && rv_a[p]) others++;
      check({tag, " valid"}, 32'(rv_a[1]), 32'(rv));
      check({tag, " extra_pulse"}, others, 0);
      check({tag, " sum"}, 32'(sum_a[1]), 32'(sum));
      check({tag, " diff"}, 32'(diff_a[1]), 32'(diff));
      check({tag, " borrow"}, 32'(bor_a[1]), 32'(bor));
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      pos           = 3'd6;
      bus.A_IN      = '0;
      bus.B_IN      = '0;
      bus.IN_VALID  = 1'b0;
      bus.CTRL_IN_B = 3'd0;
      bus.CTRL_IN_A = 1'b0;
      bus.CARRY_IN  = 1'b1;
      clear_obs();

      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check("rst sum",    32'(sum_a[7]),  0);
      check("rst diff",   32'(diff_a[7]), 0);
      check("rst borrow", 32'(bor_a[7]),  0);
      check("rst valid",  32'(rv_a[7]),   0);
      check("rst sync",   32'(sync_a[7]), 0);
      check("rst ready",  32'(rdy_a[7]),  0);

      frame(4'h5, 4'h3, 1'b1, -1, 1'b0);
      check("f1 ready_load", 32'(rdy_a[0]), 1);
      check("f1 ready_mid",  32'(rdy_a[3]), 0);
      check("f1 serial_sum",  32'({ser_a[4], ser_a[3], ser_a[2], ser_a[1]}), 32'h8);
      check("f1 serial_diff", 32'({ser_a[7], ser_a[6], ser_a[5]}), 32'h2);

      frame(4'h3, 4'h5, 1'b1, -1, 1'b0);
      check_result("5+3", 1'b1, 5'h08, 4'h2, 1'b0);
      frame(4'h0, 4'h1, 1'b1, -1, 1'b0);
      check_result("3-5", 1'b1, 5'h08, 4'hE, 1'b1);
      frame(4'hF, 4'hF, 1'b1, -1, 1'b0);
      check_result("0-1", 1'b1, 5'h01, 4'hF, 1'b1);
      frame(4'hF, 4'h1, 1'b1, -1, 1'b0);
      check_result("F+F", 1'b1, 5'h1E, 4'h0, 1'b0);
      frame(4'h9, 4'h4, 1'b1, -1, 1'b0);
      check_result("F+1", 1'b1, 5'h10, 4'hE, 1'b0);
      frame(4'h2, 4'h7, 1'b0, -1, 1'b0);
      check_result("9+4", 1'b1, 5'h0D, 4'h5, 1'b0);
      frame(4'hC, 4'h6, 1'b1, -1, 1'b0);
      check_result("novalid_hold", 1'b0, 5'h0D, 4'h5, 1'b0);

      frame(4'h7, 4'h2, 1'b1, 3, 1'b0);
      check_result("C+6", 1'b1, 5'h12, 4'h6, 1'b0);
      check("midrst sum",    32'(sum_a[4]),  0);
      check("midrst diff",   32'(diff_a[4]), 0);
      check("midrst borrow", 32'(bor_a[4]),  0);
      check("midrst valid",  32'(rv_a[4]),   0);

      frame(4'hA, 4'h3, 1'b1, -1, 1'b0);
      check_result("midrst_nopulse", 1'b0, 5'h00, 4'h0, 1'b0);

      frame(4'h4, 4'h4, 1'b1, -1, 1'b1);
      check_result("A+3", 1'b1, 5'h0D, 4'h7, 1'b0);
      check("skip sync_same",  32'(sync_a[5]),  0);
      check("skip sync_next",  32'(sync_a[6]),  1);
      check("skip sync_nochk", 32'(sync0_a[6]), 0);

      frame(4'h1, 4'h2, 1'b1, -1, 1'b0);
      check_result("err_nopulse", 1'b0, 5'h0D, 4'h7, 1'b0);
      check("sync sticky", 32'(sync_a[7]), 1);

      frame(4'h0, 4'h0, 1'b0, 3, 1'b0);
      check_result("1-2", 1'b1, 5'h03, 4'hF, 1'b1);
      check("sync before_rst", 32'(sync_a[3]),  1);
      check("sync after_rst",  32'(sync_a[4]),  0);
      check("nochk sync",      32'(sync0_a[3]), 0);
      check("nochk sum",       32'(sum0_a[1]),  32'h03);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
